// File: rtl/hgcal_input_packer.sv
// Quantizes signed samples to Q_W bits and packs NUM_FEATURES of them per frame for layer0.
// Define HGCAL_INPUT_PACKER_SAT_CNT_EN to add the sat_count port (positive saturation counter).
module hgcal_input_packer #(
    parameter int SAMPLE_W     = 8,
    parameter int NUM_FEATURES = 4,
    parameter int Q_W          = 2,
    parameter int SHIFT        = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [SAMPLE_W-1:0]         in_data,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NUM_FEATURES*Q_W-1:0] out_data,
    output logic                        err_short,
    output logic                        err_long
`ifdef HGCAL_INPUT_PACKER_SAT_CNT_EN
    ,
    output logic [15:0]                 sat_count
`endif
);
    localparam int IDX_W = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES - 1);
    localparam logic signed [SAMPLE_W-1:0] QMAX = SAMPLE_W'((1 << Q_W) - 1);

    logic [IDX_W-1:0]                 idx;
    logic [NUM_FEATURES-1:0][Q_W-1:0] pack;
    logic [NUM_FEATURES-1:0][Q_W-1:0] frame;
    logic signed [SAMPLE_W-1:0]       s;
    logic [Q_W-1:0]                   q;
    logic                             sat_hi;
    logic                             at_end;
    logic                             accept;
    logic                             close;

    always_comb begin
        s      = $signed(in_data) >>> SHIFT;
        sat_hi = !s[SAMPLE_W-1] && (s > QMAX);
        if (s[SAMPLE_W-1])
            q = '0;
        else if (sat_hi)
            q = QMAX[Q_W-1:0];
        else
            q = s[Q_W-1:0];
    end

    // Only a closing sample needs output space; everything else lands in the pack register.
    assign at_end   = (idx == LAST_IDX);
    assign in_ready = (!at_end && !in_last) || !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign close    = accept && (at_end || in_last);

    always_comb begin
        frame = '0;
        for (int i = 0; i < NUM_FEATURES; i++) begin
            if (i < int'(idx))
                frame[i] = pack[i];
            else if (i == int'(idx))
                frame[i] = q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            pack      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            err_short <= 1'b0;
            err_long  <= 1'b0;
        end else begin
            err_short <= close && in_last && !at_end;
            err_long  <= close && at_end && !in_last;
            if (close) begin
                idx       <= '0;
                pack      <= '0;
                out_data  <= frame;
                out_valid <= 1'b1;
            end else begin
                if (accept) begin
                    pack[idx] <= q;
                    idx       <= idx + IDX_W'(1);
                end
                if (out_valid && out_ready)
                    out_valid <= 1'b0;
            end
        end
    end

`ifdef HGCAL_INPUT_PACKER_SAT_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            sat_count <= '0;
        else if (accept && sat_hi && sat_count != 16'hFFFF)
            sat_count <= sat_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_hgcal_input_packer.sv
// Bench for hgcal_input_packer: directed scenarios plus randomized traffic against a queue-based frame model.
module tb_hgcal_input_packer;
    localparam int NF = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, out_valid, err_short, err_long;
    logic [7:0] out_data;
`ifdef HGCAL_INPUT_PACKER_SAT_CNT_EN
    logic [15:0] sat_count;
`endif

    int vectors = 0;
    int miscompares = 0;
    int exp_es = 0, exp_el = 0, obs_es = 0, obs_el = 0;
    logic [7:0] exp_q[$];
    int cur[$];
    bit rand_ready = 1'b0;

    always #5 clk = ~clk;

    hgcal_input_packer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data),
        .err_short(err_short), .err_long(err_long)
`ifdef HGCAL_INPUT_PACKER_SAT_CNT_EN
        , .sat_count(sat_count)
`endif
    );

    // Floor of v/16 clamped to [0,3]; any negative sample floors below zero.
    function automatic int quant(input logic [7:0] d);
        int v;
        v = int'($signed(d));
        if (v < 0) return 0;
        v = v / 16;
        return (v > 3) ? 3 : v;
    endfunction

    task automatic model_accept(input logic [7:0] d, input bit last);
        cur.push_back(quant(d));
        if (cur.size() == NF || last) begin
            logic [7:0] f;
            f = 8'h00;
            if (last && cur.size() < NF) exp_es++;
            if (!last && cur.size() == NF) exp_el++;
            foreach (cur[i]) f = f + 8'(cur[i] * (1 << (2 * i)));
            exp_q.push_back(f);
            cur.delete();
        end
    endtask

    task automatic send(input logic [7:0] d, input bit last);
        int n;
        n = 0;
        in_valid = 1'b1; in_data = d; in_last = last;
        #1;
        while (!in_ready) begin
            @(negedge clk); #1; n++;
            if (n > 200) begin
                vectors++; miscompares++;
                $display("FAIL send_timeout: in_ready=%b, required 1 within 200 cycles", in_ready);
                in_valid = 1'b0; in_last = 1'b0;
                return;
            end
        end
        @(posedge clk);
        model_accept(d, last);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        exp_q.delete(); cur.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Every consumed frame is checked against the model; error pulses are tallied.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (err_short) obs_es++;
            if (err_long) obs_el++;
            if (out_valid && out_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL frame_extra: out_data=%h, required no frame", out_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        miscompares++;
                        $display("FAIL frame_data: out_data=%h, required %h", out_data, e);
                    end
                end
            end
        end
    end

    always @(negedge clk) if (rand_ready) out_ready = 1'($urandom_range(0, 1));

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        vectors++; if (out_data !== 8'h00) begin miscompares++; $display("FAIL reset_out_data: got %h, required 00", out_data); end
        vectors++; if ({err_short, err_long} !== 2'b00) begin miscompares++; $display("FAIL reset_err: got %b, required 00", {err_short, err_long}); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic;
        out_ready = 1'b1;
        send(8'h25, 0); send(8'h7F, 0); send(8'h80, 0); send(8'h10, 1);
        #1;
        vectors++; if (out_valid !== 1'b1 || out_data !== 8'h4E) begin miscompares++; $display("FAIL basic_frame: valid=%b data=%h, required 1/4e", out_valid, out_data); end
        vectors++; if ({err_short, err_long} !== 2'b00) begin miscompares++; $display("FAIL basic_err: got %b, required 00", {err_short, err_long}); end
        @(negedge clk); #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_valid_drop: got %b, required 0", out_valid); end
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        out_ready = 1'b0;
        send(8'h25, 0); send(8'h7F, 0); send(8'h80, 0); send(8'h10, 1);
        send(8'h10, 0); send(8'h20, 0); send(8'h30, 0);
        in_valid = 1'b1; in_data = 8'h7F; in_last = 1'b1;
        #1;
        repeat (3) begin
            vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready: got %b, required 0", in_ready); end
            vectors++; if (out_valid !== 1'b1 || out_data !== 8'h4E) begin miscompares++; $display("FAIL bp_hold: valid=%b data=%h, required 1/4e", out_valid, out_data); end
            @(negedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release: in_ready=%b, required 1", in_ready); end
        @(posedge clk);
        model_accept(8'h7F, 1);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        #1;
        vectors++; if (out_valid !== 1'b1 || out_data !== 8'hF9) begin miscompares++; $display("FAIL bp_second: valid=%b data=%h, required 1/f9", out_valid, out_data); end
        @(negedge clk);
    endtask

    task automatic test_short;
        out_ready = 1'b1;
        send(8'h30, 0); send(8'h20, 1);
        #1;
        vectors++; if (out_data !== 8'h0B) begin miscompares++; $display("FAIL short_data: got %h, required 0b", out_data); end
        vectors++; if (err_short !== 1'b1 || err_long !== 1'b0) begin miscompares++; $display("FAIL short_err: got %b%b, required 10", err_short, err_long); end
        @(negedge clk); #1;
        vectors++; if (err_short !== 1'b0) begin miscompares++; $display("FAIL short_pulse_width: got %b, required 0", err_short); end
    endtask

    task automatic test_long;
        out_ready = 1'b1;
        repeat (4) send(8'h10, 0);
        #1;
        vectors++; if (out_data !== 8'h55) begin miscompares++; $display("FAIL long_data: got %h, required 55", out_data); end
        vectors++; if (err_long !== 1'b1 || err_short !== 1'b0) begin miscompares++; $display("FAIL long_err: got %b%b, required 01", err_short, err_long); end
        @(negedge clk); #1;
        vectors++; if (err_long !== 1'b0) begin miscompares++; $display("FAIL long_pulse_width: got %b, required 0", err_long); end
        @(negedge clk);
        send(8'h30, 1);
        #1;
        vectors++; if (out_data !== 8'h03) begin miscompares++; $display("FAIL long_idx_wrap: got %h, required 03", out_data); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        out_ready = 1'b0;
        send(8'h10, 0); send(8'h10, 0); send(8'h10, 0); send(8'h10, 1);
        send(8'h7F, 0); send(8'h7F, 0);
        rst = 1'b1;
        exp_q.delete(); cur.delete();
        @(negedge clk); #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_valid: got %b, required 0", out_valid); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_in_ready: got %b, required 1", in_ready); end
        rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        send(8'h7F, 0); send(8'h7F, 0); send(8'h7F, 0); send(8'h7F, 1);
        #1;
        vectors++; if (out_data !== 8'hFF || err_short !== 1'b0) begin miscompares++; $display("FAIL rstmid_frame: data=%h es=%b, required ff/0", out_data, err_short); end
        @(negedge clk);
    endtask

    task automatic test_random;
        int n;
        rand_ready = 1'b1;
        for (int k = 0; k < 600; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(8'($urandom), ($urandom_range(0, 4) == 0));
        end
        send(8'($urandom), 1);
        rand_ready = 1'b0;
        #1 out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
        @(negedge clk); #3;
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL rand_drain: %0d frames pending, required 0", exp_q.size()); end
        vectors++; if (obs_es != exp_es) begin miscompares++; $display("FAIL rand_err_short_count: got %0d, required %0d", obs_es, exp_es); end
        vectors++; if (obs_el != exp_el) begin miscompares++; $display("FAIL rand_err_long_count: got %0d, required %0d", obs_el, exp_el); end
    endtask

`ifdef HGCAL_INPUT_PACKER_SAT_CNT_EN
    task automatic test_sat_cnt;
        do_reset();
        out_ready = 1'b1;
        repeat (5) send(8'h7F, 0);
        repeat (3) send(8'h80, 0);
        #1;
        vectors++; if (sat_count !== 16'd5) begin miscompares++; $display("FAIL sat_early: got %0d, required 5", sat_count); end
        repeat (70000) send(8'h7F, 0);
        #1;
        vectors++; if (sat_count !== 16'hFFFF) begin miscompares++; $display("FAIL sat_max: got %h, required ffff", sat_count); end
        repeat (4) send(8'h80, 0);
        repeat (4) send(8'h7F, 0);
        #1;
        vectors++; if (sat_count !== 16'hFFFF) begin miscompares++; $display("FAIL sat_hold: got %h, required ffff", sat_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_short();
        test_long();
        test_reset_mid();
        test_random();
`ifdef HGCAL_INPUT_PACKER_SAT_CNT_EN
        test_sat_cnt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hgcal_input_packer.md
Name: hgcal_input_packer

Overview:
- Upstream feeder for the first LUT layer of the HGCAL autoencoder. The layer0 neurons take a packed 8-bit vector: 4 features of 2 bits each.
- This block accepts a stream of signed raw sensor samples, one per cycle, and quantizes each to 2 bits by arithmetic shift and saturation.
- It packs NUM_FEATURES quantized values into one frame and presents the frame to the layer0 LUT array through a registered valid/ready interface.

Parameters:
- SAMPLE_W, 8, width of the raw signed input sample.
- NUM_FEATURES, 4, quantized features per output frame.
- Q_W, 2, bits per quantized feature.
- SHIFT, 4, arithmetic right-shift applied before saturation.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  a sample is present on in_data.
- in_ready  output  1  the block accepts in_data this cycle.
- in_data  input  SAMPLE_W  raw sample, two's complement.
- in_last  input  1  marks the final sample of a frame.
- out_valid  output  1  out_data holds a complete frame.
- out_ready  input  1  downstream accepts the frame.
- out_data  output  NUM_FEATURES*Q_W  packed frame; feature i occupies bits [Q_W*i+Q_W-1 : Q_W*i].
- err_short  output  1  one-cycle pulse: frame closed early by in_last.
- err_long  output  1  one-cycle pulse: frame filled without in_last.

Behaviour:
- Reset values: out_valid=0, out_data=0, err_short=0, err_long=0, feature index idx=0, pack register=0. in_ready is 1 out of reset.
- Quantization (combinational on in_data):
  - s = in_data >>> SHIFT (signed).
  - If s<0, q=0.
  - Else if s > 2^Q_W-1, q=2^Q_W-1.
  - Else q = s[Q_W-1:0].
- Accept condition: in_valid && in_ready. On accept, q is written into pack slot idx.
- Frame close occurs on accept when idx==NUM_FEATURES-1 or in_last==1.
  - The closing sample and all earlier slots are transferred to the output register in the same edge. Slots above the closing idx are zero-filled.
  - idx returns to 0 and the pack register clears.
- Otherwise, on accept, idx increments.
- Error pulses (one cycle, in the cycle after the closing edge):
  - err_short: close due to in_last with idx<NUM_FEATURES-1.
  - err_long: close at idx==NUM_FEATURES-1 with in_last==0.
- in_ready = (idx != NUM_FEATURES-1 && !in_last) || !out_valid || out_ready. Non-closing samples are never stalled; only a closing sample waits for output space.
- Output register:
  - out_valid rises the cycle after a close.
  - out_valid && out_ready with no simultaneous close: out_valid drops to 0 and out_data holds its last value.
  - Simultaneous consume and close: the new frame is loaded and out_valid stays 1. This gives back-to-back throughput of one frame per NUM_FEATURES cycles.
  - out_data is stable while out_valid && !out_ready.
- Latency: the closing sample's accept edge to out_valid is 1 cycle.
- Reset mid-frame: the partial frame is discarded, idx=0, and any pending output frame is dropped (out_valid=0).
- in_valid low: no state change. idx holds and partial frames persist indefinitely.

Optional Feature:
- Macro HGCAL_INPUT_PACKER_SAT_CNT_EN.
- When defined:
  - Adds output port sat_count [15:0], reset to 0.
  - Increments once per accepted sample whose s exceeded 2^Q_W-1 (negative clamps are not counted).
  - Saturates at 16'hFFFF and does not wrap.
- When undefined: the port and counter are absent, and all other behaviour is identical.

Test Plan:
- Defaults; samples 0x25, 0x7F, 0x80, 0x10 back-to-back, in_last on the 4th, out_ready=1 -> out_valid=1 for one cycle, out_data=8'h4E, no error pulses.
- Same 4 samples with out_ready=0 -> out_valid held high and out_data=8'h4E stable. Next frame's first 3 samples are accepted; the 4th sees in_ready=0 until out_ready=1. Release -> second frame follows with no loss.
- Samples 0x30, 0x20 with in_last on the 2nd -> out_data=8'h0B (f0=3, f1=2, f2=f3=0), err_short pulses once.
- 4 samples of 0x10 with in_last never asserted -> out_data=8'h55, err_long pulses once, idx wraps to 0.
- rst asserted after 2 accepted samples -> next cycle out_valid=0 and in_ready=1. The following full frame of 0x7F x4 gives 8'hFF.
- Feature enabled; 70000 samples of 0x7F -> sat_count=16'hFFFF and holds there. Samples of 0x80 never increment it.
